// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: assembles little-endian instruction words, plus an optional
// STORE address operand, from the RX FIFO and presents them to the controller.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_rx_empty, i_rx_data, o_rx_re     RX FIFO read side (data valid the cycle after o_rx_re)
//   o_instr, o_addr, o_addr_valid      presented instruction and optional store address
//   o_instr_valid, i_instr_ready       presentation handshake
//   o_illegal_op                       one-cycle pulse when an opcode 6/7 word is dropped
//   o_halted                           HALT accepted; fetching stopped until reset
//   o_instr_count                      saturating count of accepted instructions
module instr_fetch_unit #(
   parameter int FIFO_DATA_WIDTH  = 8,
   parameter int BUFFER_WORD_SIZE = 16,
   parameter int OPCODE_WIDTH     = 3,
   parameter int ADDRESS_SIZE     = 9,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_rx_empty,
   input  logic [FIFO_DATA_WIDTH-1:0]  i_rx_data,
   output logic                        o_rx_re,
   output logic [BUFFER_WORD_SIZE-1:0] o_instr,
   output logic [ADDRESS_SIZE-1:0]     o_addr,
   output logic                        o_addr_valid,
   output logic                        o_instr_valid,
   input  logic                        i_instr_ready,
   output logic                        o_illegal_op,
   output logic                        o_halted,
   output logic [COUNT_WIDTH-1:0]      o_instr_count
);
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = '0;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_ILL   = OPCODE_WIDTH'(6);

   typedef enum logic [3:0] {
      I_LO_REQ, I_LO_CAP, I_HI_REQ, I_HI_CAP,
      A_LO_REQ, A_LO_CAP, A_HI_REQ, A_HI_CAP,
      PRESENT, HALTED
   } state_t;

   state_t                        r_state;
   logic [BUFFER_WORD_SIZE-1:0]   r_instr;
   logic [ADDRESS_SIZE-1:0]       r_addr;
   logic                          r_addr_valid;
   logic                          r_instr_valid;
   logic                          r_illegal_op;
   logic                          r_halted;
   logic [COUNT_WIDTH-1:0]        r_count;
   logic                          w_req;
   logic                          w_pop;
   logic [OPCODE_WIDTH-1:0]       w_op;

   assign w_req = (r_state == I_LO_REQ) || (r_state == I_HI_REQ) ||
                  (r_state == A_LO_REQ) || (r_state == A_HI_REQ);
   assign w_pop = w_req && !i_rx_empty;
   // The pop strobe is combinational, so it must be gated by reset explicitly.
   assign o_rx_re = w_pop && !i_rst;
   assign w_op = r_instr[OPCODE_WIDTH-1:0];

   assign o_instr       = r_instr;
   assign o_addr        = r_addr;
   assign o_addr_valid  = r_addr_valid;
   assign o_instr_valid = r_instr_valid;
   assign o_illegal_op  = r_illegal_op;
   assign o_halted      = r_halted;
   assign o_instr_count = r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= I_LO_REQ;
         r_instr       <= '0;
         r_addr        <= '0;
         r_addr_valid  <= 1'b0;
         r_instr_valid <= 1'b0;
         r_illegal_op  <= 1'b0;
         r_halted      <= 1'b0;
         r_count       <= '0;
      end else begin
         r_illegal_op <= 1'b0;
         case (r_state)
            I_LO_REQ: if (w_pop) r_state <= I_LO_CAP;
            I_LO_CAP: begin
               r_instr[7:0] <= i_rx_data;
               r_state      <= I_HI_REQ;
            end
            I_HI_REQ: if (w_pop) r_state <= I_HI_CAP;
            // Opcode and the address-follows bit live in the low byte, already captured.
            I_HI_CAP: begin
               r_instr[BUFFER_WORD_SIZE-1:8] <= i_rx_data;
               if (w_op >= OP_ILL) begin
                  r_illegal_op <= 1'b1;
                  r_state      <= I_LO_REQ;
               end else if (w_op == OP_STORE && r_instr[4]) begin
                  r_state <= A_LO_REQ;
               end else begin
                  r_instr_valid <= 1'b1;
                  r_state       <= PRESENT;
               end
            end
            A_LO_REQ: if (w_pop) r_state <= A_LO_CAP;
            A_LO_CAP: begin
               r_addr[7:0] <= i_rx_data;
               r_state     <= A_HI_REQ;
            end
            A_HI_REQ: if (w_pop) r_state <= A_HI_CAP;
            A_HI_CAP: begin
               r_addr[ADDRESS_SIZE-1:8] <= i_rx_data[ADDRESS_SIZE-9:0];
               r_addr_valid             <= 1'b1;
               r_instr_valid            <= 1'b1;
               r_state                  <= PRESENT;
            end
            PRESENT: if (i_instr_ready) begin
               r_instr_valid <= 1'b0;
               r_addr_valid  <= 1'b0;
               if (r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
               if (w_op == OP_HALT) begin
                  r_halted <= 1'b1;
                  r_state  <= HALTED;
               end else begin
                  r_state <= I_LO_REQ;
               end
            end
            HALTED: r_state <= HALTED;
            default: r_state <= I_LO_REQ;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a byte-stream parsing model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_empty;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_re;
   logic [15:0] instr;
   logic [8:0]  addr;
   logic        addr_valid;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        illegal_op;
   logic        halted;
   logic [15:0] instr_count;

   logic [7:0]  mem [0:4095];
   logic [11:0] wr_ptr = '0;
   logic [11:0] rd_ptr = '0;
   logic        starve = 1'b0;

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int illegals = 0;
   logic [15:0] acc_instr[$];
   logic [8:0]  acc_addr[$];
   logic        acc_av[$];

   always #5 clk = ~clk;

   assign rx_empty = starve || (wr_ptr == rd_ptr);

   instr_fetch_unit dut (
      .i_clk(clk), .i_rst(rst), .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_re(rx_re),
      .o_instr(instr), .o_addr(addr), .o_addr_valid(addr_valid), .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready), .o_illegal_op(illegal_op), .o_halted(halted),
      .o_instr_count(instr_count)
   );

   // FIFO read side: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      if (rx_re) begin
         rx_data <= mem[rd_ptr];
         rd_ptr  <= rd_ptr + 12'd1;
      end
   end

   // Observe just before each rising edge, after the negedge-driven inputs settle.
   always begin
      @(negedge clk);
      #4;
      if (rx_re) pops++;
      if (illegal_op) illegals++;
      if (instr_valid && instr_ready) begin
         acc_instr.push_back(instr);
         acc_addr.push_back(addr);
         acc_av.push_back(addr_valid);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 12'd1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      starve = 1'b0;
      tick(2);
      rst = 1'b0;
      wr_ptr = rd_ptr;
      pops = 0;
      illegals = 0;
      acc_instr.delete();
      acc_addr.delete();
      acc_av.delete();
   endtask

   task automatic wait_acc(input int n, input int budget);
      int c = 0;
      while (acc_instr.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("acc_timeout", acc_instr.size() >= n, 1);
   endtask

   logic [15:0] exp_instr[$];
   logic [8:0]  exp_addr[$];
   logic        exp_av[$];
   int          exp_ill;

   // Reference: walk the byte stream by the opcode rules, listing what should be presented.
   task automatic model(input logic [7:0] s[$]);
      int i = 0;
      logic [7:0] lo;
      exp_instr.delete();
      exp_addr.delete();
      exp_av.delete();
      exp_ill = 0;
      while (i + 1 < s.size()) begin
         lo = s[i];
         exp_instr.push_back({s[i+1], lo});
         i += 2;
         if (lo[2:0] >= 3'd6) begin
            exp_instr.pop_back();
            exp_ill++;
         end else if (lo[2:0] == 3'd0 && lo[4]) begin
            exp_addr.push_back({s[i+1][0], s[i]});
            exp_av.push_back(1'b1);
            i += 2;
         end else begin
            exp_addr.push_back(9'h0);
            exp_av.push_back(1'b0);
         end
      end
   endtask

   initial begin
      logic [7:0] vpat;
      logic [7:0] rpat;
      logic [11:0] vpat2;
      logic [11:0] rpat2;
      logic [7:0] stream[$];
      int bad_i, bad_r, bad_v, c;
      logic [7:0] lo;

      // Reset state
      #2;
      chk("rst_instr", instr, 16'h0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_rx_re", rx_re, 0);

      // RUN word: pop timing and presentation in cycle 4
      do_reset();
      instr_ready = 1'b1;
      push(8'h3A); push(8'h5C);
      for (int k = 0; k < 8; k++) begin
         #4;
         vpat[k] = instr_valid;
         rpat[k] = rx_re;
         @(negedge clk);
      end
      chk("run_valid_pat", vpat, 8'b0001_0000);
      chk("run_pop_pat", rpat, 8'b0000_0101);
      chk("run_instr", acc_instr[0], 16'h5C3A);
      chk("run_av", acc_av[0], 0);
      chk("run_count", instr_count, 1);

      // STORE with address: presented in cycle 8
      do_reset();
      push(8'h10); push(8'h00); push(8'h23); push(8'hFF);
      for (int k = 0; k < 12; k++) begin
         #4;
         vpat2[k] = instr_valid;
         rpat2[k] = rx_re;
         @(negedge clk);
      end
      chk("st_valid_pat", vpat2, 12'b0001_0000_0000);
      chk("st_pop_pat", rpat2, 12'b0000_0101_0101);
      chk("st_instr", acc_instr[0], 16'h0010);
      chk("st_addr", acc_addr[0], 9'h123);
      chk("st_av", acc_av[0], 1);
      chk("st_av_clear", addr_valid, 0);

      // STORE without address, then FETCH
      do_reset();
      push(8'h00); push(8'h00); push(8'h01); push(8'h00);
      wait_acc(2, 40);
      chk("sn_instr0", acc_instr[0], 16'h0000);
      chk("sn_av0", acc_av[0], 0);
      chk("sn_instr1", acc_instr[1], 16'h0001);
      chk("sn_av1", acc_av[1], 0);
      chk("sn_pops", pops, 4);

      // Back-pressure
      do_reset();
      instr_ready = 1'b0;
      push(8'h02); push(8'h81); push(8'h05); push(8'h00);
      c = 0;
      while (!instr_valid && c < 20) begin @(negedge clk); c++; end
      chk("bp_valid_timeout", instr_valid, 1);
      bad_i = 0; bad_r = 0; bad_v = 0;
      for (int k = 0; k < 10; k++) begin
         #4;
         if (instr !== 16'h8102) bad_i++;
         if (rx_re) bad_r++;
         if (!instr_valid) bad_v++;
         @(negedge clk);
      end
      chk("bp_instr_stable", bad_i, 0);
      chk("bp_no_pop", bad_r, 0);
      chk("bp_valid_held", bad_v, 0);
      instr_ready = 1'b1;
      wait_acc(2, 30);
      chk("bp_instr0", acc_instr[0], 16'h8102);
      chk("bp_instr1", acc_instr[1], 16'h0005);

      // FIFO starved between low and high byte
      do_reset();
      push(8'h03);
      bad_v = 0;
      for (int k = 0; k < 20; k++) begin
         #4;
         if (instr_valid) bad_v++;
         @(negedge clk);
      end
      chk("starve_no_valid", bad_v, 0);
      push(8'h40);
      wait_acc(1, 20);
      chk("starve_instr", acc_instr[0], 16'h4003);

      // Illegal opcode then HALT
      do_reset();
      push(8'h07); push(8'h00);
      tick(8);
      chk("ill_pulse", illegals, 1);
      chk("ill_no_present", acc_instr.size(), 0);
      push(8'h04); push(8'h00);
      wait_acc(1, 20);
      tick(1);
      chk("halt_flag", halted, 1);
      chk("halt_instr", acc_instr[0], 16'h0004);
      push(8'h02); push(8'h00);
      tick(10);
      chk("halt_no_pop", pops, 4);
      chk("halt_no_valid", instr_valid, 0);
      chk("halt_count", instr_count, 1);

      // Asynchronous reset mid-address
      do_reset();
      push(8'h10); push(8'h00); push(8'h23);
      tick(10);
      chk("ar_pending_addr", addr, 9'h023);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_instr", instr, 16'h0);
      chk("ar_addr", addr, 9'h0);
      chk("ar_av", addr_valid, 0);
      chk("ar_rx_re", rx_re, 0);
      do_reset();
      push(8'h02); push(8'h00);
      wait_acc(1, 20);
      chk("ar_next_instr", acc_instr[0], 16'h0002);
      chk("ar_next_av", acc_av[0], 0);

      // Randomized stream with random ready/starvation, terminated by HALT
      do_reset();
      stream.delete();
      for (int n = 0; n < 40; n++) begin
         lo = 8'($urandom_range(0, 255));
         if (lo[2:0] == 3'd4) lo[2:0] = 3'd5;
         stream.push_back(lo);
         stream.push_back(8'($urandom_range(0, 255)));
         if (lo[2:0] == 3'd0 && lo[4]) begin
            stream.push_back(8'($urandom_range(0, 255)));
            stream.push_back(8'($urandom_range(0, 255)));
         end
      end
      stream.push_back(8'h04);
      stream.push_back(8'h00);
      foreach (stream[k]) push(stream[k]);
      model(stream);
      c = 0;
      while (!halted && c < 4000) begin
         instr_ready = 1'($urandom_range(0, 1));
         starve = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         c++;
      end
      starve = 1'b0;
      tick(2);
      chk("rnd_halted", halted, 1);
      chk("rnd_n_present", acc_instr.size(), exp_instr.size());
      chk("rnd_illegals", illegals, exp_ill);
      chk("rnd_pops", pops, stream.size());
      chk("rnd_count", instr_count, exp_instr.size());
      for (int k = 0; k < exp_instr.size() && k < acc_instr.size(); k++) begin
         chk("rnd_instr", acc_instr[k], exp_instr[k]);
         chk("rnd_av", acc_av[k], exp_av[k]);
         if (exp_av[k]) chk("rnd_addr", acc_addr[k], exp_addr[k]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
